// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the 16-bit byte-addressed memory front end (mem_ctrl).
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;

  typedef enum logic {
    ACC_WORD = 1'b0,
    ACC_BYTE = 1'b1
  } acc_size_e;

  function automatic acc_size_e acc_from_byt(input logic byt);
    return byt ? ACC_BYTE : ACC_WORD;
  endfunction

endpackage

// File: rtl/mem_lane_swap.sv
// 16-bit conditional byte swap, shared by the write-lane split and the read reassembly.
module mem_lane_swap (
  input  logic        swap_en,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  always_comb begin
    dout = swap_en ? {din[7:0], din[15:8]} : din;
  end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-to-dual-8-bit-BRAM front end: lo bank = even bytes, hi bank = odd bytes.
// Odd-address word accesses are only honoured when MEM_UNALIGNED_EN is defined.
module mem_ctrl #(
  parameter int ADDR_WIDTH = mem_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  bram_rst,
  output logic                  bram_clk,
  output logic                  wr_lo,
  output logic                  wr_hi,
  output logic [ADDR_WIDTH-2:0] addr_lo,
  output logic [ADDR_WIDTH-2:0] addr_hi,
  output logic [7:0]            wr_data_lo,
  output logic [7:0]            wr_data_hi,
  input  logic [7:0]            rd_data_lo,
  input  logic [7:0]            rd_data_hi
);

  import mem_ctrl_pkg::*;

  acc_size_e             acc_d, acc_q;
  logic                  odd_d, odd_q;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [15:0]           wr_src;
  logic [15:0]           wr_lanes;
  logic [15:0]           rd_lanes;

  assign bram_clk = clk;
  assign bram_rst = ~rst;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_d = acc_from_byt(byt);
`ifdef MEM_UNALIGNED_EN
    odd_d = addr[0];
`else
    // Word accesses ignore A[0]; byte accesses still pick the bank by A[0].
    odd_d = (acc_d == ACC_BYTE) ? addr[0] : 1'b0;
`endif
  end

  // The lo bank serves the byte after an odd address, hence the increment before the shift.
  always_comb begin
    addr_inc = addr + ADDR_WIDTH'(odd_d);
    addr_hi  = addr[ADDR_WIDTH-1:1];
    addr_lo  = addr_inc[ADDR_WIDTH-1:1];
  end

  always_comb begin
    wr_lo = 1'b0;
    wr_hi = 1'b0;
    if (acc_d == ACC_BYTE) begin
      wr_lo = wr & ~addr[0];
      wr_hi = wr &  addr[0];
    end else begin
      wr_lo = wr;
      wr_hi = wr;
    end
  end

  always_comb begin
    wr_src = (acc_d == ACC_BYTE) ? {wr_data[7:0], wr_data[7:0]} : wr_data;
  end

  mem_lane_swap u_wr_swap (
    .swap_en (odd_d & (acc_d == ACC_WORD)),
    .din     (wr_src),
    .dout    (wr_lanes)
  );

  assign wr_data_hi = wr_lanes[15:8];
  assign wr_data_lo = wr_lanes[7:0];

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      odd_q <= 1'b0;
      acc_q <= ACC_WORD;
    end else begin
      odd_q <= odd_d;
      acc_q <= acc_d;
    end
  end

  mem_lane_swap u_rd_swap (
    .swap_en (odd_q & (acc_q == ACC_WORD)),
    .din     ({rd_data_hi, rd_data_lo}),
    .dout    (rd_lanes)
  );

  // Gating on rst makes the read bus zero the instant reset asserts, not at the next RAM edge.
  always_comb begin
    rd_data = '0;
    if (rst) begin
      if (acc_q == ACC_BYTE) begin
        rd_data = {8'h00, (odd_q ? rd_data_hi : rd_data_lo)};
      end else begin
        rd_data = rd_lanes;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a read-first behavioural model of the two byte RAMs.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic        wr = 1'b0;
  logic        byt = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        bram_rst, bram_clk;
  logic        wr_lo, wr_hi;
  logic [14:0] addr_lo, addr_hi;
  logic [7:0]  wr_data_lo, wr_data_hi;
  logic [7:0]  rd_data_lo = '0;
  logic [7:0]  rd_data_hi = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_lo [32768];
  logic [7:0] mem_hi [32768];

  mem_ctrl #(.ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wr         (wr),
    .byt        (byt),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .bram_rst   (bram_rst),
    .bram_clk   (bram_clk),
    .wr_lo      (wr_lo),
    .wr_hi      (wr_hi),
    .addr_lo    (addr_lo),
    .addr_hi    (addr_hi),
    .wr_data_lo (wr_data_lo),
    .wr_data_hi (wr_data_hi),
    .rd_data_lo (rd_data_lo),
    .rd_data_hi (rd_data_hi)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem_lo[i] = 8'h00;
      mem_hi[i] = 8'h00;
    end
  end

  // Read-first synchronous RAMs clocked from the forwarded clock.
  always @(posedge bram_clk) begin
    if (bram_rst) begin
      rd_data_lo <= 8'h00;
      rd_data_hi <= 8'h00;
    end else begin
      rd_data_lo <= mem_lo[addr_lo];
      rd_data_hi <= mem_hi[addr_hi];
    end
    if (wr_lo) mem_lo[addr_lo] <= wr_data_lo;
    if (wr_hi) mem_hi[addr_hi] <= wr_data_hi;
  end

  task automatic drive(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
    addr = a; wr = w; byt = b; wr_data = d;
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    vectors++; if (bram_rst !== 1'b1) begin miscompares++; $display("FAIL reset_bram_rst got %b want 1", bram_rst); end
    @(negedge clk);
    vectors++; if (bram_clk !== 1'b0) begin miscompares++; $display("FAIL bram_clk got %b want 0", bram_clk); end
    rst = 1'b1;
    #1;
    vectors++; if (bram_rst !== 1'b0) begin miscompares++; $display("FAIL release_bram_rst got %b want 0", bram_rst); end
  endtask

  task automatic test_word();
    drive(16'h0300, 1'b1, 1'b0, 16'h1234);
    vectors++; if ({wr_lo, wr_hi} !== 2'b11) begin miscompares++; $display("FAIL word_wr_en got %b want 11", {wr_lo, wr_hi}); end
    vectors++; if (addr_lo !== 15'h0180 || addr_hi !== 15'h0180) begin miscompares++; $display("FAIL word_addr got lo=%h hi=%h want 0180/0180", addr_lo, addr_hi); end
    vectors++; if (wr_data_lo !== 8'h34 || wr_data_hi !== 8'h12) begin miscompares++; $display("FAIL word_lanes got lo=%h hi=%h want 34/12", wr_data_lo, wr_data_hi); end
    @(negedge clk);
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    vectors++; if ({wr_lo, wr_hi} !== 2'b00) begin miscompares++; $display("FAIL read_wr_en got %b want 00", {wr_lo, wr_hi}); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h1234) begin miscompares++; $display("FAIL word_read got %h want 1234", rd_data); end
  endtask

  task automatic test_byte_read();
    drive(16'h0301, 1'b0, 1'b1, 16'h0000);
    vectors++; if (addr_hi !== 15'h0180 || addr_lo !== 15'h0181) begin miscompares++; $display("FAIL byte_odd_addr got lo=%h hi=%h want 0181/0180", addr_lo, addr_hi); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h0012) begin miscompares++; $display("FAIL byte_read_301 got %h want 0012", rd_data); end
    drive(16'h0300, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h0034) begin miscompares++; $display("FAIL byte_read_300 got %h want 0034", rd_data); end
  endtask

  task automatic test_byte_write();
    drive(16'h0300, 1'b1, 1'b1, 16'hFF77);
    vectors++; if ({wr_lo, wr_hi} !== 2'b10) begin miscompares++; $display("FAIL byte_even_wr_en got %b want 10", {wr_lo, wr_hi}); end
    vectors++; if (wr_data_lo !== 8'h77 || wr_data_hi !== 8'h77) begin miscompares++; $display("FAIL byte_lanes got lo=%h hi=%h want 77/77", wr_data_lo, wr_data_hi); end
    @(negedge clk);
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h1277) begin miscompares++; $display("FAIL byte_write_readback got %h want 1277", rd_data); end
  endtask

  task automatic test_read_during_write();
    drive(16'h0300, 1'b1, 1'b0, 16'h5555);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h1277) begin miscompares++; $display("FAIL rdw_old got %h want 1277", rd_data); end
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h5555) begin miscompares++; $display("FAIL rdw_new got %h want 5555", rd_data); end
  endtask

  task automatic test_back_to_back();
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h5555) begin miscompares++; $display("FAIL b2b_word got %h want 5555", rd_data); end
    drive(16'h0303, 1'b1, 1'b1, 16'h00EE);
    vectors++; if ({wr_lo, wr_hi} !== 2'b01 || addr_hi !== 15'h0181) begin miscompares++; $display("FAIL b2b_byte_odd_wr got en=%b addr_hi=%h want 01/0181", {wr_lo, wr_hi}, addr_hi); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL b2b_write_old got %h want 0000", rd_data); end
    drive(16'h0303, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h00EE) begin miscompares++; $display("FAIL b2b_byte_read got %h want 00ee", rd_data); end
  endtask

  task automatic test_unaligned();
    drive(16'h0301, 1'b1, 1'b0, 16'hABCD);
`ifdef MEM_UNALIGNED_EN
    vectors++; if (addr_hi !== 15'h0180 || addr_lo !== 15'h0181) begin miscompares++; $display("FAIL unal_addr got lo=%h hi=%h want 0181/0180", addr_lo, addr_hi); end
    vectors++; if (wr_data_hi !== 8'hCD || wr_data_lo !== 8'hAB) begin miscompares++; $display("FAIL unal_lanes got lo=%h hi=%h want ab/cd", wr_data_lo, wr_data_hi); end
`else
    vectors++; if (addr_hi !== 15'h0180 || addr_lo !== 15'h0180) begin miscompares++; $display("FAIL unal_addr got lo=%h hi=%h want 0180/0180", addr_lo, addr_hi); end
    vectors++; if (wr_data_hi !== 8'hAB || wr_data_lo !== 8'hCD) begin miscompares++; $display("FAIL unal_lanes got lo=%h hi=%h want cd/ab", wr_data_lo, wr_data_hi); end
`endif
    @(negedge clk);
    drive(16'h0301, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'hABCD) begin miscompares++; $display("FAIL unal_read got %h want abcd", rd_data); end
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
`ifdef MEM_UNALIGNED_EN
    vectors++; if (rd_data !== 16'hCD55) begin miscompares++; $display("FAIL unal_neighbour got %h want cd55", rd_data); end
`else
    vectors++; if (rd_data !== 16'hABCD) begin miscompares++; $display("FAIL unal_neighbour got %h want abcd", rd_data); end
`endif
  endtask

  task automatic test_reset_mid_read();
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL midrst_rd_data got %h want 0000", rd_data); end
    vectors++; if (bram_rst !== 1'b1) begin miscompares++; $display("FAIL midrst_bram_rst got %b want 1", bram_rst); end
    drive(16'h0400, 1'b1, 1'b0, 16'h0000);
    vectors++; if ({wr_lo, wr_hi} !== 2'b11) begin miscompares++; $display("FAIL midrst_wr_en got %b want 11", {wr_lo, wr_hi}); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL midrst_hold got %h want 0000", rd_data); end
    rst = 1'b1;
    drive(16'h0301, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
`ifdef MEM_UNALIGNED_EN
    vectors++; if (rd_data !== 16'h00CD) begin miscompares++; $display("FAIL post_rst_byte got %h want 00cd", rd_data); end
`else
    vectors++; if (rd_data !== 16'h00AB) begin miscompares++; $display("FAIL post_rst_byte got %h want 00ab", rd_data); end
`endif
    drive(16'h0300, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
`ifdef MEM_UNALIGNED_EN
    vectors++; if (rd_data !== 16'hCD55) begin miscompares++; $display("FAIL post_rst_word got %h want cd55", rd_data); end
`else
    vectors++; if (rd_data !== 16'hABCD) begin miscompares++; $display("FAIL post_rst_word got %h want abcd", rd_data); end
`endif
  endtask

  task automatic test_addr_wrap();
    drive(16'hFFFF, 1'b1, 1'b1, 16'h005A);
    vectors++; if ({wr_lo, wr_hi} !== 2'b01) begin miscompares++; $display("FAIL wrap_wr_en got %b want 01", {wr_lo, wr_hi}); end
    vectors++; if (addr_hi !== 15'h7FFF || addr_lo !== 15'h0000) begin miscompares++; $display("FAIL wrap_addr got lo=%h hi=%h want 0000/7fff", addr_lo, addr_hi); end
    @(negedge clk);
    drive(16'hFFFF, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    vectors++; if (rd_data !== 16'h005A) begin miscompares++; $display("FAIL wrap_byte_read got %h want 005a", rd_data); end
    drive(16'hFFFF, 1'b0, 1'b0, 16'h0000);
`ifdef MEM_UNALIGNED_EN
    vectors++; if (addr_lo !== 15'h0000) begin miscompares++; $display("FAIL wrap_word_addr got %h want 0000", addr_lo); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h005A) begin miscompares++; $display("FAIL wrap_word_read got %h want 005a", rd_data); end
`else
    vectors++; if (addr_lo !== 15'h7FFF) begin miscompares++; $display("FAIL wrap_word_addr got %h want 7fff", addr_lo); end
    @(negedge clk);
    vectors++; if (rd_data !== 16'h5A00) begin miscompares++; $display("FAIL wrap_word_read got %h want 5a00", rd_data); end
`endif
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_word();
    test_byte_read();
    test_byte_write();
    test_read_during_write();
    test_back_to_back();
    test_unaligned();
    test_reset_mid_read();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
